// File: rtl/mult_round_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mult_round_pipe
// Description : Two-stage rounding and renormalisation back end for a
//               floating-point multiplier, with valid/ready handshaking.
//               Stage 1 decides the rounding increment from the guard and
//               sticky bits and adds it to the unrounded significand.
//               Stage 2 absorbs any carry-out by shifting the significand
//               and bumping the exponent, then holds the result for
//               downstream.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   in_valid       in   operand valid
//   in_ready       out  operand accepted this cycle when in_valid is high
//   round_mode     in   00 nearest-even, 01 toward zero, 10 +inf, 11 -inf
//   Sgn_X, Sgn_Y   in   operand signs
//   Sgf_PR         in   unrounded significand, hidden bit at MSB
//   Sgf_round_bits in   discarded bits; MSB = guard, rest = sticky
//   Exp_in         in   biased exponent before rounding
//   out_valid      out  result valid
//   out_ready      in   downstream accepts the result
//   Sgn_Info       out  result sign
//   Sgf_out        out  rounded, renormalised significand
//   Exp_out        out  exponent after rounding
//   inexact        out  nonzero bits were discarded
//   exp_ovf        out  exponent after rounding is all-ones
// ============================================================================
module mult_round_pipe #(
    parameter int W_Sgf = 23,
    parameter int W_Exp = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         round_mode,
    input  logic               Sgn_X,
    input  logic               Sgn_Y,
    input  logic [W_Sgf:0]     Sgf_PR,
    input  logic [W_Sgf-1:0]   Sgf_round_bits,
    input  logic [W_Exp-1:0]   Exp_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               Sgn_Info,
    output logic [W_Sgf:0]     Sgf_out,
    output logic [W_Exp-1:0]   Exp_out,
    output logic               inexact,
    output logic               exp_ovf
);

    localparam logic [1:0] c_RM_NEAREST_EVEN = 2'b00;
    localparam logic [1:0] c_RM_TOWARD_ZERO  = 2'b01;
    localparam logic [1:0] c_RM_TOWARD_PINF  = 2'b10;
    localparam logic [1:0] c_RM_TOWARD_NINF  = 2'b11;

    // ------------------------------------------------------------------
    // Stage 1 combinational: rounding decision and increment
    // ------------------------------------------------------------------
    logic               w_guard;
    logic               w_sticky;
    logic               w_inexact_d;
    logic               w_sgn_d;
    logic               w_inc_d;
    logic [W_Sgf+1:0]   w_sum_d;

    assign w_guard     = Sgf_round_bits[W_Sgf-1];
    assign w_sticky    = |Sgf_round_bits[W_Sgf-2:0];
    assign w_inexact_d = w_guard | w_sticky;
    assign w_sgn_d     = Sgn_X ^ Sgn_Y;

    always_comb begin
        w_inc_d = 1'b0;
        case (round_mode)
            // Round up above half, or at exactly half when the LSB is odd.
            c_RM_NEAREST_EVEN: w_inc_d = w_guard & (w_sticky | Sgf_PR[0]);
            c_RM_TOWARD_ZERO:  w_inc_d = 1'b0;
            c_RM_TOWARD_PINF:  w_inc_d = w_inexact_d & ~w_sgn_d;
            c_RM_TOWARD_NINF:  w_inc_d = w_inexact_d &  w_sgn_d;
            default:           w_inc_d = 1'b0;
        endcase
    end

    // One extra bit on top catches the carry from 1.111..1 + ulp.
    assign w_sum_d = {1'b0, Sgf_PR} + {{(W_Sgf+1){1'b0}}, w_inc_d};

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic               s1_valid_q;
    logic               s1_sgn_q;
    logic               s1_inexact_q;
    logic [W_Sgf+1:0]   s1_sum_q;
    logic [W_Exp-1:0]   s1_exp_q;

    // ------------------------------------------------------------------
    // Stage 2 registers (drive the outputs directly)
    // ------------------------------------------------------------------
    logic               s2_valid_q;
    logic               s2_sgn_q;
    logic               s2_inexact_q;
    logic [W_Sgf:0]     s2_sgf_q;
    logic [W_Exp-1:0]   s2_exp_q;
    logic               s2_ovf_q;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic w_s2_adv;
    logic w_s1_adv;

    // Stage 2 can take new data when it is empty or its result leaves now.
    assign w_s2_adv = ~s2_valid_q | out_ready;
    assign w_s1_adv = s1_valid_q & w_s2_adv;
    assign in_ready = ~s1_valid_q | w_s1_adv;

    // ------------------------------------------------------------------
    // Stage 2 combinational: renormalise on carry-out
    // ------------------------------------------------------------------
    logic               w_carry;
    logic [W_Sgf:0]     w_sgf_d;
    logic [W_Exp-1:0]   w_exp_d;
    logic               w_ovf_d;

    assign w_carry = s1_sum_q[W_Sgf+1];
    // On carry the sum is exactly 10.00..0, so the dropped LSB is zero and
    // shifting right does not require another rounding step.
    assign w_sgf_d = w_carry ? s1_sum_q[W_Sgf+1:1] : s1_sum_q[W_Sgf:0];
    assign w_exp_d = s1_exp_q + {{(W_Exp-1){1'b0}}, w_carry};
    assign w_ovf_d = &w_exp_d;

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sgn_q     <= 1'b0;
            s1_inexact_q <= 1'b0;
            s1_sum_q     <= '0;
            s1_exp_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_sgn_q     <= 1'b0;
            s2_inexact_q <= 1'b0;
            s2_sgf_q     <= '0;
            s2_exp_q     <= '0;
            s2_ovf_q     <= 1'b0;
        end else begin
            // When in_ready is high, stage 1 is either empty or emptying
            // into stage 2 this cycle, so it can be overwritten.
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_sgn_q     <= w_sgn_d;
                    s1_inexact_q <= w_inexact_d;
                    s1_sum_q     <= w_sum_d;
                    s1_exp_q     <= Exp_in;
                end
            end
            // Output fields only change when a new result lands, so a
            // stalled result stays stable.
            if (w_s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_sgn_q     <= s1_sgn_q;
                    s2_inexact_q <= s1_inexact_q;
                    s2_sgf_q     <= w_sgf_d;
                    s2_exp_q     <= w_exp_d;
                    s2_ovf_q     <= w_ovf_d;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign Sgn_Info  = s2_sgn_q;
    assign Sgf_out   = s2_sgf_q;
    assign Exp_out   = s2_exp_q;
    assign inexact   = s2_inexact_q;
    assign exp_ovf   = s2_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_round_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_round_pipe
// Description : Self-checking bench for mult_round_pipe (W_Sgf=23, W_Exp=8).
//               Directed cases plus randomized traffic checked against an
//               arithmetic rounding model through an in-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_round_pipe;

    typedef struct packed {
        logic [1:0]  mode;
        logic        sx;
        logic        sy;
        logic [23:0] pr;
        logic [22:0] rb;
        logic [7:0]  ex;
    } op_t;

    typedef struct packed {
        logic        sgn;
        logic [23:0] sgf;
        logic [7:0]  ex;
        logic        inx;
        logic        ovf;
    } res_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  round_mode;
    logic        Sgn_X;
    logic        Sgn_Y;
    logic [23:0] Sgf_PR;
    logic [22:0] Sgf_round_bits;
    logic [7:0]  Exp_in;
    logic        out_valid;
    logic        out_ready;
    logic        Sgn_Info;
    logic [23:0] Sgf_out;
    logic [7:0]  Exp_out;
    logic        inexact;
    logic        exp_ovf;

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   n_drained = 0;
    logic obs_in_ready;
    logic obs_out_valid;
    res_t exp_q[$];
    op_t  idle_op;
    op_t  op_a;

    mult_round_pipe #(.W_Sgf(23), .W_Exp(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .round_mode     (round_mode),
        .Sgn_X          (Sgn_X),
        .Sgn_Y          (Sgn_Y),
        .Sgf_PR         (Sgf_PR),
        .Sgf_round_bits (Sgf_round_bits),
        .Exp_in         (Exp_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .Sgn_Info       (Sgn_Info),
        .Sgf_out        (Sgf_out),
        .Exp_out        (Exp_out),
        .inexact        (inexact),
        .exp_ovf        (exp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Reference rounding: compare the discarded fraction against one half,
    // round, and renormalise if the significand reached 2.0.
    function automatic res_t model(input op_t o);
        res_t        r;
        logic        sgn;
        bit          up;
        longint unsigned half;
        longint unsigned rem;
        longint unsigned s;
        int unsigned e;
        sgn  = o.sx ^ o.sy;
        half = 64'd1 << 22;
        rem  = o.rb;
        case (o.mode)
            2'd0:    up = (rem > half) || (rem == half && (o.pr % 2) == 1);
            2'd1:    up = 1'b0;
            2'd2:    up = (rem != 0) && !sgn;
            default: up = (rem != 0) && sgn;
        endcase
        s = longint'(o.pr) + (up ? 1 : 0);
        e = o.ex;
        if (s >= (64'd1 << 24)) begin
            s = s / 2;
            e = (e + 1) % 256;
        end
        r.sgn = sgn;
        r.sgf = s[23:0];
        r.ex  = e[7:0];
        r.inx = (rem != 0);
        r.ovf = (e == 255);
        return r;
    endfunction

    // One clock cycle: drive at the falling edge, then check the outputs
    // and record the transfers that the next rising edge will perform.
    task automatic step(input op_t o, input logic v, input logic ordy, input logic r);
        res_t f;
        @(negedge clk);
        rst            = r;
        in_valid       = v;
        out_ready      = ordy;
        round_mode     = o.mode;
        Sgn_X          = o.sx;
        Sgn_Y          = o.sy;
        Sgf_PR         = o.pr;
        Sgf_round_bits = o.rb;
        Exp_in         = o.ex;
        #1;
        obs_in_ready  = in_ready;
        obs_out_valid = out_valid;
        if (!r) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    f = exp_q[0];
                    check("sgn", Sgn_Info, f.sgn);
                    check("sgf", Sgf_out, f.sgf);
                    check("exp", Exp_out, f.ex);
                    check("inexact", inexact, f.inx);
                    check("exp_ovf", exp_ovf, f.ovf);
                    if (ordy) begin
                        void'(exp_q.pop_front());
                        n_drained++;
                    end
                end
            end
            if (v && in_ready) exp_q.push_back(model(o));
        end
    endtask

    task automatic run_single(input string tag, input op_t o, input logic [23:0] w_sgf,
                              input logic [7:0] w_exp, input logic w_inx, input logic w_ovf,
                              input logic w_sgn);
        step(o, 1'b1, 1'b1, 1'b0);
        check({tag, "_in_ready"}, obs_in_ready, 1);
        step(idle_op, 1'b0, 1'b1, 1'b0);
        check({tag, "_early_valid"}, obs_out_valid, 0);
        step(idle_op, 1'b0, 1'b1, 1'b0);
        check({tag, "_valid"}, obs_out_valid, 1);
        check({tag, "_sgf"}, Sgf_out, w_sgf);
        check({tag, "_exp"}, Exp_out, w_exp);
        check({tag, "_inexact"}, inexact, w_inx);
        check({tag, "_ovf"}, exp_ovf, w_ovf);
        check({tag, "_sgn"}, Sgn_Info, w_sgn);
    endtask

    function automatic op_t mk(input logic [1:0] m, input logic sx, input logic sy,
                               input logic [23:0] pr, input logic [22:0] rb, input logic [7:0] ex);
        op_t o;
        o.mode = m; o.sx = sx; o.sy = sy; o.pr = pr; o.rb = rb; o.ex = ex;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.mode = 2'($urandom_range(0, 3));
        o.sx   = 1'($urandom_range(0, 1));
        o.sy   = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            0:       o.pr = 24'hFFFFFF;
            1:       o.pr = 24'hFFFFFE;
            default: o.pr = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
        endcase
        case ($urandom_range(0, 4))
            0:       o.rb = 23'h000000;
            1:       o.rb = 23'h400000;
            2:       o.rb = 23'h400001;
            3:       o.rb = 23'h3FFFFF;
            default: o.rb = 23'($urandom_range(0, 23'h7FFFFF));
        endcase
        case ($urandom_range(0, 3))
            0:       o.ex = 8'hFE;
            1:       o.ex = 8'hFF;
            default: o.ex = 8'($urandom_range(0, 255));
        endcase
        return o;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_outputs"}, {Sgn_Info, Sgf_out, Exp_out, inexact, exp_ovf}, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        idle_op = '0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        round_mode = 2'b00; Sgn_X = 1'b0; Sgn_Y = 1'b0;
        Sgf_PR = '0; Sgf_round_bits = '0; Exp_in = '0;

        // Reset state
        step(idle_op, 1'b0, 1'b0, 1'b1);
        step(idle_op, 1'b0, 1'b0, 1'b1);
        step(idle_op, 1'b0, 1'b1, 1'b0);
        check_idle_zero("reset");

        // Directed rounding cases
        run_single("tie_odd_ne",   mk(2'b00, 0, 0, 24'h800001, 23'h400000, 8'h80), 24'h800002, 8'h80, 1, 0, 0);
        run_single("tie_even_ne",  mk(2'b00, 0, 0, 24'h800000, 23'h400000, 8'h80), 24'h800000, 8'h80, 1, 0, 0);
        run_single("tie_even_rz",  mk(2'b01, 0, 0, 24'h800000, 23'h400000, 8'h80), 24'h800000, 8'h80, 1, 0, 0);
        run_single("carry_pinf",   mk(2'b10, 0, 0, 24'hFFFFFF, 23'h000001, 8'h7F), 24'h800000, 8'h80, 1, 0, 0);
        run_single("carry_ovf",    mk(2'b10, 0, 0, 24'hFFFFFF, 23'h000001, 8'hFE), 24'h800000, 8'hFF, 1, 1, 0);
        run_single("neg_pinf",     mk(2'b10, 1, 0, 24'hFFFFFF, 23'h000001, 8'h7F), 24'hFFFFFF, 8'h7F, 1, 0, 1);
        run_single("neg_ninf",     mk(2'b11, 1, 0, 24'hFFFFFF, 23'h000001, 8'h7F), 24'h800000, 8'h80, 1, 0, 1);
        run_single("exact_ne",     mk(2'b00, 1, 1, 24'hABCDEF, 23'h000000, 8'h10), 24'hABCDEF, 8'h10, 0, 0, 0);

        // Backpressure: two accepts, then in_ready drops until drain
        n_drained = 0;
        step(mk(2'b00, 0, 0, 24'h800001, 23'h400000, 8'h01), 1'b1, 1'b0, 1'b0);
        check("bp_accept1", obs_in_ready, 1);
        step(mk(2'b01, 1, 0, 24'h900000, 23'h7FFFFF, 8'h02), 1'b1, 1'b0, 1'b0);
        check("bp_accept2", obs_in_ready, 1);
        op_a = mk(2'b10, 0, 0, 24'hFFFFFF, 23'h000001, 8'h03);
        step(op_a, 1'b1, 1'b0, 1'b0);
        check("bp_stall1", obs_in_ready, 0);
        step(op_a, 1'b1, 1'b0, 1'b0);
        check("bp_stall2", obs_in_ready, 0);
        step(op_a, 1'b1, 1'b1, 1'b0);
        check("bp_release", obs_in_ready, 1);
        for (int i = 0; i < 4; i++) step(idle_op, 1'b0, 1'b1, 1'b0);
        check("bp_drained", n_drained, 3);
        check("bp_queue_empty", exp_q.size(), 0);

        // Reset mid-stream with two operands in flight
        step(mk(2'b00, 0, 1, 24'hC00001, 23'h600000, 8'h40), 1'b1, 1'b0, 1'b0);
        step(mk(2'b11, 1, 0, 24'hC00003, 23'h000010, 8'h41), 1'b1, 1'b0, 1'b0);
        step(idle_op, 1'b0, 1'b0, 1'b1);
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            step(idle_op, 1'b0, 1'b1, 1'b0);
            check_idle_zero("mid_reset");
        end

        // Randomized traffic with random stalls
        for (int i = 0; i < 600; i++) begin
            step(rand_op(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 1'b0);
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            step(idle_op, 1'b0, 1'b1, 1'b0);
        end
        check("final_drain", exp_q.size(), 0);
        step(idle_op, 1'b0, 1'b1, 1'b0);
        check("final_idle", obs_out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mult_round_pipe.md
MULT_ROUND_PIPE -- requirements
Module: mult_round_pipe

Interface
REQ-001 Parameter: W_Sgf, default 23, significand fraction width (52 for double precision).
REQ-002 Parameter: W_Exp, default 8, biased exponent width (11 for double precision).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  upstream operand valid.
REQ-006 in_ready  output  1  block accepts the operand this cycle.
REQ-007 round_mode  input  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
REQ-008 Sgn_X, Sgn_Y  input  1 each  operand signs.
REQ-009 Sgf_PR  input  W_Sgf+1  unrounded significand, hidden bit at MSB.
REQ-010 Sgf_round_bits  input  W_Sgf  discarded product bits; MSB is the guard bit, remaining bits form sticky.
REQ-011 Exp_in  input  W_Exp  biased exponent before rounding.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 Sgn_Info  output  1  result sign.
REQ-015 Sgf_out  output  W_Sgf+1  rounded, renormalised significand.
REQ-016 Exp_out  output  W_Exp  exponent after rounding.
REQ-017 inexact  output  1  rounding discarded nonzero bits.
REQ-018 exp_ovf  output  1  rounding pushed the exponent to all-ones.

Function
REQ-019 Transfer in occurs when in_valid & in_ready; transfer out occurs when out_valid & out_ready.
REQ-020 Pipeline is 2 stages. S1 registers sign, the increment decision and the (W_Sgf+2)-bit sum Sgf_PR + inc. S2 renormalises and drives the outputs.
REQ-021 Latency is 2 cycles from accepted input to out_valid with no stall; throughput is 1 result per cycle.
REQ-022 Sign: Sgn_Info = Sgn_X XOR Sgn_Y, registered with its operand.
REQ-023 Guard G = Sgf_round_bits[W_Sgf-1]; sticky S = OR of Sgf_round_bits[W_Sgf-2:0]; inexact = G | S.
REQ-024 Increment: mode 00 -> G & (S | Sgf_PR[0]); mode 01 -> 0; mode 10 -> inexact & ~sign; mode 11 -> inexact & sign.
REQ-025 Carry C = sum[W_Sgf+1]. C=1 -> Sgf_out = sum[W_Sgf+1:1] and Exp_out = Exp_in + 1. C=0 -> Sgf_out = sum[W_Sgf:0] and Exp_out = Exp_in.
REQ-026 Exponent add is modulo 2^W_Exp; exp_ovf = 1 iff the computed Exp_out equals all-ones.
REQ-027 Stage registers advance only when the next stage is empty or draining in the same cycle; an output held with out_ready=0 stays stable.
REQ-028 in_ready = ~S1_valid | (S1 advancing into S2); in_ready is combinational and does not depend on in_valid.
REQ-029 Simultaneous accept and drain in one cycle neither loses nor duplicates data; results leave in acceptance order.
REQ-030 round_mode is sampled with its operand; a mode change affects only operands accepted afterwards.

Reset
REQ-031 With rst high at a clock edge, both stage valid bits clear. All outputs reset to 0 (out_valid, Sgn_Info, Sgf_out, Exp_out, inexact, exp_ovf); in_ready reads 1 from the first cycle after reset.
REQ-032 Reset asserted mid-operation discards all in-flight results; no out_valid pulse follows for those operands.

Verification (W_Sgf=23, W_Exp=8)
REQ-033 Tie, odd LSB, mode 00: Sgf_PR=0x800001, round_bits=0x400000, Exp_in=0x80 -> 2 cycles later Sgf_out=0x800002, Exp_out=0x80, inexact=1.
REQ-034 Tie, even LSB, mode 00: Sgf_PR=0x800000, round_bits=0x400000 -> Sgf_out=0x800000, inexact=1. Same operand in mode 01 -> 0x800000.
REQ-035 Carry, mode 10, signs 0/0: Sgf_PR=0xFFFFFF, round_bits=0x000001, Exp_in=0x7F -> Sgf_out=0x800000, Exp_out=0x80, exp_ovf=0. Same with Exp_in=0xFE -> Exp_out=0xFF, exp_ovf=1. Signs 1/0 in mode 10 -> no increment, Sgf_out=0xFFFFFF, Sgn_Info=1.
REQ-036 Backpressure: out_ready=0, 3 back-to-back inputs -> in_ready drops after 2 accepts. Releasing out_ready -> 3 results in order, none lost or duplicated.
REQ-037 Reset mid-stream: 2 operands in flight, rst pulsed 1 cycle -> no out_valid afterwards, all outputs 0, in_ready=1.
